// File: rtl/btn_cmd_in.sv
// Push-button conditioner: sync, tick-based debounce, press and long-press pulses.
// Optional auto-repeat on the four direction buttons with `define BTN_REPEAT_EN.
module btn_cmd_in #(
    parameter int TICK_DIV   = 100000,
    parameter int DEB_TICKS  = 20,
    parameter int LONG_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic       long_press,
    output logic       tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    level_d;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] dcnt [5];
    logic [HW-1:0] hcnt;
    logic          armed;
    logic [4:0]    rep_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // tick is registered one count early so it is high while tcnt == TICK_LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);
            tick <= (tcnt == TICK_PRE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= '0;
            for (int i = 0; i < 5; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    dcnt[i] <= '0;
                end else if (tick) begin
                    if (dcnt[i] == DEB_LAST) begin
                        btn_level[i] <= ~btn_level[i];
                        dcnt[i]      <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d   <= '0;
            btn_press <= '0;
        end else begin
            level_d   <= btn_level;
            btn_press <= (btn_level & ~level_d) | rep_hit;
        end
    end

    // Hold counter saturates at LONG_TICKS; armed allows one pulse per hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt       <= '0;
            armed      <= 1'b1;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!btn_level[4]) begin
                hcnt  <= '0;
                armed <= 1'b1;
            end else if (tick && hcnt != HOLD_MAX) begin
                hcnt <= hcnt + HW'(1);
                if (hcnt == HOLD_LAST && armed) begin
                    long_press <= 1'b1;
                    armed      <= 1'b0;
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int REP_FIRST = (LONG_TICKS / 2 > 0) ? LONG_TICKS / 2 : 1;
    localparam int REP_GAP   = (LONG_TICKS / 4 > 0) ? LONG_TICKS / 4 : 1;
    localparam int RW        = $clog2(REP_FIRST + 1);

    localparam logic [RW-1:0] FIRST_LAST = RW'(REP_FIRST - 1);
    localparam logic [RW-1:0] GAP_LAST   = RW'(REP_GAP - 1);

    logic [RW-1:0] rcnt [4];
    logic [3:0]    rep_on;

    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < 4; i++) begin
            rep_hit[i] = btn_level[i] && tick &&
                         (rcnt[i] == (rep_on[i] ? GAP_LAST : FIRST_LAST));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_on <= '0;
            for (int i = 0; i < 4; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!btn_level[i]) begin
                    rcnt[i]   <= '0;
                    rep_on[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    rcnt[i]   <= '0;
                    rep_on[i] <= 1'b1;
                end else if (tick) begin
                    rcnt[i] <= rcnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rep_hit = '0;
`endif

endmodule

// File: doc/btn_cmd_in.md
Name: btn_cmd_in

Overview:
- Input-side counterpart of the seven-segment status output path: conditions the five EGO1 push buttons into clean command events for the car state machine.
- Per button: 2-flop synchronizer, tick-based debouncer, one-cycle press pulse.
- The centre button also gets a long-press pulse, used for power on/off.
- Sits between the board pins and the top-level state machine.

Parameters:
- TICK_DIV, 100000: clk cycles per debounce tick (1 ms at 100 MHz); minimum 2.
- DEB_TICKS, 20: consecutive ticks of disagreement needed before the stable level flips; minimum 1.
- LONG_TICKS, 1000: ticks the centre button must stay stably high before long_press fires; minimum 1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- btn_raw  input  5  raw pins: [0] up, [1] down, [2] left, [3] right, [4] centre; active-high.
- btn_level  output  5  debounced stable level per button.
- btn_press  output  5  one-cycle pulse per button on a debounced 0->1 transition.
- long_press  output  1  one-cycle pulse when the centre button has been held LONG_TICKS ticks.
- tick  output  1  one-cycle debounce tick strobe, exported for other timers.

Behaviour:
- Reset (async, rst=1): synchronizer flops, btn_level, btn_press, long_press, tick, tick counter, debounce counters and hold counter all go to 0; the long-press armed flag goes to 1. Release is taken on the next posedge.
- Synchronizer: two flops per bit. sync = btn_raw delayed 2 clk.
- Tick generator:
  - Counter 0..TICK_DIV-1, wraps to 0.
  - tick=1 for exactly the one cycle in which the counter equals TICK_DIV-1, so the period is exactly TICK_DIV cycles.
- Debounce, per bit i, with a counter wide enough for DEB_TICKS:
  - If sync[i]==btn_level[i] in any cycle, the counter clears to 0, regardless of tick.
  - Else, on a tick cycle:
    - If counter==DEB_TICKS-1: btn_level[i] toggles and the counter clears.
    - Otherwise the counter increments.
  - Else (no tick): hold.
  - Glitches shorter than one full disagreement window never change btn_level.
- Press: btn_press[i] is registered, =1 in the cycle after btn_level[i] goes 0->1, for exactly 1 cycle. No pulse on release.
- Long press (centre, bit 4):
  - While btn_level[4]=1, the hold counter increments on each tick.
  - When it reaches LONG_TICKS with armed=1: long_press pulses 1 cycle, armed clears, and the counter saturates.
  - When btn_level[4]=0: the counter clears and armed sets.
  - Net effect: at most one long_press per hold. btn_press[4] still fires at press start.
- Simultaneous events:
  - Buttons are fully independent; several bits of btn_press may be 1 in the same cycle.
  - A tick in the same cycle as a sync/level agreement takes the clear rule.
- Reset mid-hold: all state clears immediately. A button still held after reset is treated as a new press once debounced: btn_press fires DEB_TICKS ticks later, and long_press is re-armed.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: for up/down/left/right only, while btn_level[i] stays 1, btn_press[i] additionally pulses every LONG_TICKS/4 ticks after an initial LONG_TICKS/2-tick delay (auto-repeat for continuous manual driving). Each repeat pulse is 1 cycle. The repeat counter clears on release or reset.
- Undefined: no repeat logic is synthesized; exactly one btn_press per debounced press.

Test Plan (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10):
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously. After release, tick first fires in the 4th posedge cycle and then every 4 cycles.
- Clean press: btn_raw[0] 0->1 and held -> btn_level[0]=1 after 2 sync cycles plus 3 ticks; btn_press[0]=1 for exactly 1 cycle immediately after; release debounces back with no pulse.
- Bounce: btn_raw[2] toggles every 5 cycles for 60 cycles, then settles high -> no btn_press[2] during bouncing; exactly one pulse 3 ticks (±1 tick) after settling.
- Long press: hold centre for 20 ticks -> btn_press[4] once at debounce; long_press once, 10 ticks after btn_level[4] rose; no second long_press. Release and repeat -> fires again.
- Simultaneous: btn_raw[1] and btn_raw[3] rise in the same cycle -> btn_press[1] and btn_press[3] pulse in the same cycle.
- Reset mid-hold: centre held 6 ticks, pulse rst -> no long_press; with the button still held, btn_press[4] fires 3 ticks after reset release and long_press 10 ticks after that.
